pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//  Central pipeline sequencer. Turns per-stage stall requests into one stall vector (pc,if,id,ex,mem,wb).
//  Turns commit-stage exception/ertn events from the mem->wb boundary into a timed flush window.
//  Issues a one-cycle front-end redirect (eentry / tlbrentry / era).
//  Optionally parks the core after an IDLE commit until an interrupt is pending.
// PARAMETERS
//  FLUSH_CYCLES  2  cycles flush_o stays high per event; legal range 1..15
// PORTS
//  clk               in   1   core clock
//  rst               in   1   synchronous reset, active-high
//  stallreq_if       in   1   fetch stage stall request
//  stallreq_id       in   1   decode stage stall request
//  stallreq_ex       in   1   execute stage stall request
//  stallreq_mem      in   1   memory stage stall request
//  excp_flush_i      in   1   exception committing this cycle
//  ertn_flush_i      in   1   ERTN committing this cycle
//  excp_tlbrefill_i  in   1   the committing exception is a TLB refill
//  csr_eentry_i      in   32  general exception entry
//  csr_tlbrentry_i   in   32  TLB refill entry
//  csr_era_i         in   32  ERTN return address
//  idle_commit_i     in   1   IDLE instruction committing (macro only)
//  int_pending_i     in   1   interrupt pending and enabled (macro only)
//  stall_o           out  6   bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb; 1 = hold
//  flush_o           out  1   kill all pipeline registers
//  redirect_valid_o  out  1   one-cycle pulse: load redirect_pc_o into PC
//  redirect_pc_o     out  32  redirect target
//  idle_o            out  1   core parked in IDLE_WAIT
// BEHAVIOUR
//  - States: RUN, FLUSH, IDLE_WAIT (macro only). Counter flush_cnt is 4 bits.
//  - Reset: state=RUN, flush_cnt=0. All outputs are 0 the cycle after rst is sampled high.
//  - Reset mid-FLUSH or mid-IDLE_WAIT aborts the sequence; no redirect is issued.
//  - stall_o is combinational in RUN. It is 0 in FLUSH. It is 6'b111111 in IDLE_WAIT.
//  - RUN stall encoding; the deepest requester wins:
//    - mem -> 6'b011111
//    - ex  -> 6'b001111
//    - id  -> 6'b000111
//    - if  -> 6'b000011
//    - none -> 6'b000000
//  - Any event input high (excp_flush_i | ertn_flush_i) forces stall_o=0 in that same cycle.
//  - Event sampled in RUN at cycle T:
//    - state becomes FLUSH at T+1; flush_cnt loads FLUSH_CYCLES-1.
//    - redirect_valid_o=1 at T+1 only.
//    - flush_o=1 from T+1 through T+FLUSH_CYCLES; flush_cnt decrements each FLUSH cycle.
//    - In FLUSH with flush_cnt==0, next state is RUN.
//  - Target priority, registered at T:
//    - excp & tlbrefill -> csr_tlbrentry_i
//    - excp             -> csr_eentry_i
//    - ertn             -> csr_era_i
//    - excp and ertn together -> exception wins.
//  - redirect_pc_o holds its last value between pulses; reset value is 0.
//  - In FLUSH, event inputs and stall requests are ignored; no re-trigger and no extension of the window.
//  - excp_tlbrefill_i without excp_flush_i has no effect.
// CONFIGURATION
//  - PIPE_CTRL_IDLE_EN defined:
//    - idle_commit_i in RUN with no event at T -> IDLE_WAIT at T+1; idle_o=1.
//    - IDLE_WAIT -> RUN the cycle after int_pending_i is sampled 1.
//    - An event input in IDLE_WAIT -> FLUSH, same rules as from RUN.
//  - PIPE_CTRL_IDLE_EN undefined:
//    - IDLE_WAIT is not built; idle_o is tied to 0.
//    - idle_commit_i and int_pending_i are unused.
// TESTING
//  1. rst=1 two cycles, all requests high -> after release stall_o=0, flush_o=0, redirect_valid_o=0, redirect_pc_o=0.
//  2. stallreq_if=1 and stallreq_ex=1 -> stall_o=6'b001111 same cycle; drop ex -> 6'b000011.
//  3. FLUSH_CYCLES=2, excp_flush_i pulse at T, eentry=32'h1c008000 ->
//     redirect_valid_o=1 and pc=1c008000 at T+1; flush_o=1 at T+1,T+2 and 0 at T+3.
//  4. excp_flush_i and ertn_flush_i at T, era=32'h1c000100 -> pc=eentry.
//     ertn alone -> pc=1c000100.
//     excp+tlbrefill, tlbrentry=32'h1c00f000 -> pc=1c00f000.
//  5. Second excp at T+1 inside FLUSH -> no second redirect pulse; flush ends at T+2.
//     rst at T+1 -> flush_o=0 at T+2.
//  6. (PIPE_CTRL_IDLE_EN) idle_commit_i at T -> idle_o=1, stall_o=6'b111111 from T+1.
//     int_pending_i at T+5 -> state RUN and stall_o=0 at T+6.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer: stall vector, timed flush window and front-end redirect.
// Optional IDLE parking (IDLE_WAIT state) is built only when PIPE_CTRL_IDLE_EN is defined.
module pipeline_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              excp_flush_i,
  input  logic              ertn_flush_i,
  input  logic              excp_tlbrefill_i,
  input  logic [DATA_W-1:0] csr_eentry_i,
  input  logic [DATA_W-1:0] csr_tlbrentry_i,
  input  logic [DATA_W-1:0] csr_era_i,
  input  logic              idle_commit_i,
  input  logic              int_pending_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic              redirect_valid_o,
  output logic [DATA_W-1:0] redirect_pc_o,
  output logic              idle_o
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

`ifdef PIPE_CTRL_IDLE_EN
  typedef enum logic [1:0] {RUN, FLUSH, IDLE_WAIT} state_t;
`else
  typedef enum logic [1:0] {RUN, FLUSH} state_t;
`endif

  state_t            state, state_nxt;
  logic [3:0]        flush_cnt, flush_cnt_nxt;
  logic              evt;
  logic              trig;
  logic [DATA_W-1:0] redir_tgt;
  logic              redir_vld_p1;
  logic [DATA_W-1:0] redir_pc_p1;

  // Deepest stalled stage holds itself and everything upstream of it.
  function automatic logic [5:0] stall_encode(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
    logic [5:0] v;
    v = 6'b000000;
    if (req_mem)     v = 6'b011111;
    else if (req_ex) v = 6'b001111;
    else if (req_id) v = 6'b000111;
    else if (req_if) v = 6'b000011;
    return v;
  endfunction

  assign evt = excp_flush_i | ertn_flush_i;

  // Exception beats ERTN; TLB refill only qualifies an exception.
  always_comb begin
    redir_tgt = csr_era_i;
    if (excp_flush_i) begin
      redir_tgt = excp_tlbrefill_i ? csr_tlbrentry_i : csr_eentry_i;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    trig          = 1'b0;
    case (state)
      RUN: begin
        if (evt) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FLUSH_LOAD;
          trig          = 1'b1;
        end
`ifdef PIPE_CTRL_IDLE_EN
        else if (idle_commit_i) begin
          state_nxt = IDLE_WAIT;
        end
`endif
      end
      FLUSH: begin
        if (flush_cnt == 4'd0) begin
          state_nxt = RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - 4'd1;
        end
      end
`ifdef PIPE_CTRL_IDLE_EN
      IDLE_WAIT: begin
        if (evt) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FLUSH_LOAD;
          trig          = 1'b1;
        end else if (int_pending_i) begin
          state_nxt = RUN;
        end
      end
`endif
      default: begin
        state_nxt     = RUN;
        flush_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_comb begin
    stall_o = 6'b000000;
    if (!evt) begin
      case (state)
        RUN:       stall_o = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
`ifdef PIPE_CTRL_IDLE_EN
        IDLE_WAIT: stall_o = 6'b111111;
`endif
        default:   stall_o = 6'b000000;
      endcase
    end
  end

  // ---- p1: sequencer state and registered redirect ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      flush_cnt    <= 4'd0;
      redir_vld_p1 <= 1'b0;
      redir_pc_p1  <= '0;
    end else begin
      state        <= state_nxt;
      flush_cnt    <= flush_cnt_nxt;
      redir_vld_p1 <= trig;
      if (trig) begin
        redir_pc_p1 <= redir_tgt;
      end
    end
  end

  assign flush_o          = (state == FLUSH);
  assign redirect_valid_o = redir_vld_p1;
  assign redirect_pc_o    = redir_pc_p1;

`ifdef PIPE_CTRL_IDLE_EN
  assign idle_o = (state == IDLE_WAIT);
`else
  logic unused_idle_inputs;
  assign unused_idle_inputs = idle_commit_i ^ int_pending_i;
  assign idle_o = 1'b0;
`endif

endmodule
